load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access per accepted start, with alignment check,
// byte-lane steering, load extension and a bounded wait for mem_ack.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  alucode,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Memory opcode encodings mirror define.vh.
  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic        done_q, mis_q, to_q;
  logic [31:0] load_data_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        is_mem_d, is_store_d, mis_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      ALU_LB:  extract = {{24{b[7]}}, b};
      ALU_LBU: extract = {24'd0, b};
      ALU_LH:  extract = {{16{h[15]}}, h};
      ALU_LHU: extract = {16'd0, h};
      default: extract = rd;
    endcase
  endfunction

  // Decode of the op presented with start; only consumed in IDLE.
  always_comb begin
    is_mem_d   = 1'b1;
    is_store_d = 1'b0;
    mis_d      = 1'b0;
    be_d       = 4'b0000;
    wdata_d    = 32'd0;
    case (alucode)
      ALU_LB, ALU_LBU: be_d = 4'b0001 << alu_result[1:0];
      ALU_LH, ALU_LHU: begin
        mis_d = alu_result[0];
        be_d  = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      ALU_LW: begin
        mis_d = |alu_result[1:0];
        be_d  = 4'b1111;
      end
      ALU_SB: begin
        is_store_d = 1'b1;
        be_d       = 4'b0001 << alu_result[1:0];
        wdata_d    = {4{store_data[7:0]}};
      end
      ALU_SH: begin
        is_store_d = 1'b1;
        mis_d      = alu_result[0];
        be_d       = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{store_data[15:0]}};
      end
      ALU_SW: begin
        is_store_d = 1'b1;
        mis_d      = |alu_result[1:0];
        be_d       = 4'b1111;
        wdata_d    = store_data;
      end
      default: is_mem_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 6'd0;
      off_q       <= 2'd0;
      cnt_q       <= 8'd0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      to_q        <= 1'b0;
      load_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q        <= alucode;
            off_q       <= alu_result[1:0];
            cnt_q       <= 8'd0;
            load_data_q <= 32'd0;
            if (!is_mem_d || mis_d) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              mis_q   <= is_mem_d;
            end else begin
              state_q     <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_d;
              mem_addr_q  <= {alu_result[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ACCESS: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (mem_ack || cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            done_q      <= 1'b1;
            to_q        <= !mem_ack;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if (mem_ack && !mem_we_q)
              load_data_q <= extract(op_q, off_q, mem_rdata);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          to_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign misaligned = mis_q;
  assign timeout    = to_q;
  assign load_data  = load_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed ops, per-cycle comparison against a
// transaction-level model of lanes, extension and latency.
module tb_load_store_unit;

  localparam int TO = 4;

  localparam logic [5:0] ALU_LUI = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_ack;
  logic [5:0]  alucode;
  logic [31:0] alu_result, store_data, mem_rdata;
  logic        busy, done, misaligned, timeout, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        e_busy, e_req, e_we, e_done, e_mis, e_to, e_wd_chk, e_ld_chk;
  logic [31:0] e_addr, e_wd, e_ld;
  logic [3:0]  e_be;
  bit          chk_en = 1'b0;
  bit          pinned = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucode(alucode),
    .alu_result(alu_result), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // ---------------- model ----------------
  function automatic int m_size(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: m_size = 1;
      ALU_LH, ALU_LHU, ALU_SH: m_size = 2;
      ALU_LW, ALU_SW:          m_size = 4;
      default:                 m_size = 0;
    endcase
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    m_is_store = (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] addr);
    m_misaligned = (m_size(op) != 0) && ((addr % m_size(op)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr);
    int sz;
    sz = m_size(op);
    m_be = 4'((1 << sz) - 1) << (addr % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
    case (m_size(op))
      1:       m_wdata = (sd & 32'hFF) * 32'h0101_0101;
      2:       m_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
      default: m_wdata = sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint v, range;
    int     sz;
    sz    = m_size(op);
    range = 64'd1 << (8 * sz);
    v     = (longint'(rd) >> (8 * (addr % 4))) & (range - 1);
    if ((op == ALU_LB || op == ALU_LH) && v >= range / 2) v = v - range;
    m_load = v[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (!pinned) begin
        chk("pin_lb_ext", m_load(ALU_LB, 32'h1003, 32'h8011_2233), 32'hFFFF_FF80);
        chk("pin_lb_be", {28'd0, m_be(ALU_LB, 32'h1003)}, 32'h8);
        chk("pin_sh_be", {28'd0, m_be(ALU_SH, 32'h2002)}, 32'hC);
        chk("pin_sh_wd", m_wdata(ALU_SH, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("pin_lw_mis", {31'd0, m_misaligned(ALU_LW, 32'h3001)}, 32'd1);
        chk("pin_lh_ext", m_load(ALU_LH, 32'h7002, 32'h8001_7FFF), 32'hFFFF_8001);
        chk("pin_lbu_ext", m_load(ALU_LBU, 32'h8001, 32'h1122_F344), 32'h0000_00F3);
        pinned = 1'b1;
      end
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
      chk("timeout", {31'd0, timeout}, {31'd0, e_to});
      if (e_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
        if (e_wd_chk) chk("mem_wdata", mem_wdata, e_wd);
      end
      if (e_ld_chk) chk("load_data", load_data, e_ld);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle();
    e_busy = 1'b0; e_req = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_to = 1'b0; e_wd_chk = 1'b0;
  endtask

  // waits = non-ack cycles before mem_ack; negative or >= TO means no ack.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits, input bit poke_busy);
    bit mem, mis, acked;
    mem   = (m_size(op) != 0);
    mis   = m_misaligned(op, addr);
    acked = 1'b0;
    start = 1'b1; alucode = op; alu_result = addr; store_data = sd; mem_ack = 1'b0;
    expect_idle();
    step();
    start = 1'b0; alucode = ALU_LUI; alu_result = 32'hDEAD_BEEF; store_data = 32'hFFFF_FFFF;
    e_ld_chk = 1'b0;
    if (mem && !mis) begin
      e_busy = 1'b1; e_req = 1'b1; e_we = m_is_store(op);
      e_addr = addr & 32'hFFFF_FFFC; e_be = m_be(op, addr);
      e_wd = m_wdata(op, sd); e_wd_chk = e_we;
      for (int c = 1; c <= TO; c++) begin
        start = poke_busy && (c == 1);
        if (waits >= 0 && c == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        step();
        if (acked) break;
      end
    end
    e_busy = 1'b1; e_req = 1'b0; e_wd_chk = 1'b0; e_done = 1'b1;
    e_mis = mis; e_to = mem && !mis && !acked;
    e_ld = (acked && !m_is_store(op)) ? m_load(op, addr, rd) : 32'd0;
    e_ld_chk = 1'b1;
    start = poke_busy; mem_ack = poke_busy; mem_rdata = 32'h5555_AAAA;
    step();
    start = 1'b0; mem_ack = 1'b0;
    expect_idle();
    step();
  endtask

  task automatic idle_ack();
    expect_idle();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  task automatic reset_mid_access();
    start = 1'b1; alucode = ALU_LW; alu_result = 32'h5000; store_data = 32'd0; mem_ack = 1'b0;
    expect_idle();
    step();
    start = 1'b0;
    e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h5000; e_be = 4'hF; e_ld_chk = 1'b0;
    step();
    rst_n = 1'b0;
    expect_idle();
    e_ld = 32'd0; e_ld_chk = 1'b1;
    start = 1'b1; alucode = ALU_LB;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; alucode = 6'd0;
    alu_result = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
    expect_idle();
    e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wd = 32'd0;
    e_ld = 32'd0; e_ld_chk = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_op(ALU_LB,  32'h1003, 32'd0,        32'h8011_2233, 0,  1'b0);
    run_op(ALU_SH,  32'h2002, 32'h1234_ABCD, 32'd0,        3,  1'b0);
    run_op(ALU_LW,  32'h3001, 32'd0,        32'd0,        -1, 1'b0);
    run_op(ALU_LHU, 32'h4002, 32'd0,        32'd0,        -1, 1'b0);
    run_op(ALU_LUI, 32'h1234_5678, 32'd7,   32'd0,        0,  1'b0);
    run_op(ALU_SB,  32'h6001, 32'hA5A5_5A3C, 32'd0,       1,  1'b1);
    run_op(ALU_LH,  32'h7002, 32'd0,        32'h8001_7FFF, 2,  1'b0);
    run_op(ALU_LBU, 32'h8001, 32'd0,        32'h1122_F344, 0,  1'b0);
    run_op(ALU_SW,  32'h9000, 32'hCAFE_BABE, 32'd0,       2,  1'b0);
    run_op(ALU_SH,  32'h2001, 32'h0000_1111, 32'd0,       0,  1'b0);
    run_op(ALU_LH,  32'h0003, 32'd0,        32'd0,        0,  1'b0);
    run_op(ALU_LW,  32'hA004, 32'd0,        32'h89AB_CDEF, 0,  1'b0);
    idle_ack();
    reset_mid_access();
    run_op(ALU_LB,  32'hB002, 32'd0,        32'h0055_0000, 1,  1'b1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
